can_tx_arbiter: RTL and testbench

CAN_TX_ARBITER -- requirements
Module: can_tx_arbiter

---
 rtl/can_tx_arbiter_if.sv | 45 ++++
 rtl/can_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_can_tx_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_arbiter_if.sv
// CAN TX arbiter bus: source handshakes and CAN engine request.
// master = arbiter side, slave = sources/engine side.
interface can_tx_arbiter_if #(
  parameter int DATA_W  = 128,
  parameter int NUM_SRC = 4
);
  localparam int GID_W = $clog2(NUM_SRC);

  logic                      i_cen;
  logic [NUM_SRC-1:0]        i_src_valid;
  logic [NUM_SRC*DATA_W-1:0] i_src_data;
  logic                      i_busy_can;
  logic [NUM_SRC-1:0]        o_src_r_en;
  logic [DATA_W-1:0]         o_send_data;
  logic                      o_send_en;
  logic [GID_W-1:0]          o_grant_id;
  logic                      o_done;
  logic                      o_timeout;

  modport master (
    input  i_cen,
    input  i_src_valid,
    input  i_src_data,
    input  i_busy_can,
    output o_src_r_en,
    output o_send_data,
    output o_send_en,
    output o_grant_id,
    output o_done,
    output o_timeout
  );

  modport slave (
    output i_cen,
    output i_src_valid,
    output i_src_data,
    output i_busy_can,
    input  o_src_r_en,
    input  o_send_data,
    input  o_send_en,
    input  o_grant_id,
    input  o_done,
    input  o_timeout
  );
endinterface

// File: rtl/can_tx_arbiter.sv
// CAN TX arbiter: HPB-first, round-robin or fixed among FIFOs.
// Reads one frame, presents it, waits for the busy handshake.
module can_tx_arbiter #(
  parameter int DATA_W      = 128,
  parameter int NUM_SRC     = 4,
  parameter int RR_EN       = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             i_sys_clk,
  input  logic             i_reset,
  can_tx_arbiter_if.master bus
);
  localparam int GID_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARB   = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] LATCH = 3'd3;
  localparam logic [2:0] SEND  = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GID_W-1:0] FIFO_1st = GID_W'(1);
  localparam logic [GID_W-1:0] FIFO_END = GID_W'(NUM_SRC - 1);

  logic [2:0]        state;
  logic [GID_W-1:0]  grant;
  logic [GID_W-1:0]  rr_ptr;
  logic [GID_W-1:0]  rr_next;
  logic [GID_W-1:0]  pick;
  logic [GID_W-1:0]  cand;
  logic              found;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              timeout_q;

  // Grant selection: HPB always first, then RR or lowest FIFO.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    if (bus.i_src_valid[0]) begin
      found = 1'b1;
    end else if (RR_EN != 0) begin
      for (int i = 0; i < NUM_SRC - 1; i++) begin
        cand = GID_W'((int'(rr_ptr) - 1 + i)
                      % (NUM_SRC - 1) + 1);
        if (!found && bus.i_src_valid[cand]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
    end else begin
      for (int i = NUM_SRC - 1; i >= 1; i--) begin
        cand = GID_W'(i);
        if (bus.i_src_valid[cand]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
    end
  end

  // Pointer moves past the FIFO just finished, skipping the HPB.
  always_comb begin
    rr_next = rr_ptr;
    if (grant != '0) begin
      rr_next = (grant == FIFO_END) ? FIFO_1st
                                    : grant + FIFO_1st;
    end
  end

  // Control FSM, grant/data registers and completion pulses.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= FIFO_1st;
      cnt       <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_cen) state <= ARB;
        end
        ARB: begin
          if (!bus.i_cen) begin
            state <= IDLE;
          end else if (!bus.i_busy_can && found) begin
            grant <= pick;
            state <= READ;
          end
        end
        READ: begin
          state <= LATCH;
        end
        LATCH: begin
          data_q <= bus.i_src_data[grant*DATA_W +: DATA_W];
          cnt    <= '0;
          state  <= SEND;
        end
        SEND: begin
          cnt <= cnt + CNT_ONE;
          if (bus.i_busy_can) begin
            state <= WAIT;
          end else if (cnt == CNT_LAST) begin
            timeout_q <= 1'b1;
            rr_ptr    <= rr_next;
            state     <= ARB;
          end
        end
        WAIT: begin
          if (!bus.i_busy_can) begin
            done_q <= 1'b1;
            rr_ptr <= rr_next;
            state  <= ARB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read strobe only in READ, addressed to the granted source.
  always_comb begin
    bus.o_src_r_en = '0;
    if (state == READ) bus.o_src_r_en[grant] = 1'b1;
  end

  assign bus.o_send_en   = (state == SEND);
  assign bus.o_send_data = (state == SEND) ? data_q : '0;
  assign bus.o_grant_id  = grant;
  assign bus.o_done      = done_q;
  assign bus.o_timeout   = timeout_q;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Bench for can_tx_arbiter: RR and fixed-priority instances in lockstep.
// Frame-level reference model of the grant rules.
module tb_can_tx_arbiter;
  localparam int DW = 32;
  localparam int NS = 4;

  logic               clk;
  logic               rst;
  logic               cen;
  logic [NS-1:0]      valid;
  logic [NS-1:0][DW-1:0] words;
  logic               busy;

  int n_chk;
  int n_fail;
  int last_fifo;

  can_tx_arbiter_if #(.DATA_W(DW), .NUM_SRC(NS)) bus_rr ();
  can_tx_arbiter_if #(.DATA_W(DW), .NUM_SRC(NS)) bus_fx ();

  assign bus_rr.i_cen       = cen;
  assign bus_rr.i_src_valid = valid;
  assign bus_rr.i_src_data  = words;
  assign bus_rr.i_busy_can  = busy;
  assign bus_fx.i_cen       = cen;
  assign bus_fx.i_src_valid = valid;
  assign bus_fx.i_src_data  = words;
  assign bus_fx.i_busy_can  = busy;

  can_tx_arbiter #(
    .DATA_W(DW), .NUM_SRC(NS), .RR_EN(1), .ACK_TIMEOUT(4)
  ) u_rr (
    .i_sys_clk(clk),
    .i_reset  (rst),
    .bus      (bus_rr)
  );

  can_tx_arbiter #(
    .DATA_W(DW), .NUM_SRC(NS), .RR_EN(0), .ACK_TIMEOUT(4)
  ) u_fx (
    .i_sys_clk(clk),
    .i_reset  (rst),
    .bus      (bus_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: HPB first, else next valid FIFO after last served.
  function automatic int model_rr(input logic [NS-1:0] v);
    if (v[0]) return 0;
    for (int i = 1; i < NS; i++) begin
      int s;
      s = (last_fifo + i - 1) % (NS - 1) + 1;
      if (v[s]) return s;
    end
    return -1;
  endfunction

  // Fixed rule: lowest valid index wins.
  function automatic int model_fx(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_ren_rr"},  bus_rr.o_src_r_en,  0);
    chk({tag, "_sen_rr"},  bus_rr.o_send_en,   0);
    chk({tag, "_sdat_rr"}, bus_rr.o_send_data, 0);
    chk({tag, "_gid_rr"},  bus_rr.o_grant_id,  0);
    chk({tag, "_done_rr"}, bus_rr.o_done,      0);
    chk({tag, "_to_rr"},   bus_rr.o_timeout,   0);
    chk({tag, "_ren_fx"},  bus_fx.o_src_r_en,  0);
    chk({tag, "_sen_fx"},  bus_fx.o_send_en,   0);
    chk({tag, "_gid_fx"},  bus_fx.o_grant_id,  0);
    chk({tag, "_done_fx"}, bus_fx.o_done,      0);
  endtask

  task automatic wait_read();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus_rr.o_src_r_en == '0 && k < 12);
    if (bus_rr.o_src_r_en == '0) begin
      chk("read_wait", 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $fatal(1, "FAIL read_wait: no read pulse within bound");
    end
  endtask

  task automatic idle_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus_rr.o_src_r_en != '0 || bus_fx.o_src_r_en != '0)
        seen = 1'b1;
    end
    chk(tag, seen, 0);
  endtask

  task automatic frame(input logic [NS-1:0] vld,
                       input bit ack,
                       input int dly,
                       input int blen,
                       input bit drop_cen);
    int er;
    int ef;
    er = model_rr(vld);
    ef = model_fx(vld);
    valid = vld;
    busy  = 1'b0;
    for (int s = 0; s < NS; s++) words[s] = $urandom;
    wait_read();
    chk("ren_rr", bus_rr.o_src_r_en, 64'd1 << er);
    chk("ren_fx", bus_fx.o_src_r_en, 64'd1 << ef);
    chk("gid_rr", bus_rr.o_grant_id, er);
    chk("gid_fx", bus_fx.o_grant_id, ef);
    chk("done_1cyc", bus_rr.o_done, 0);
    valid = NS'($urandom);
    @(negedge clk);
    chk("latch_ren", bus_rr.o_src_r_en, 0);
    chk("latch_sen", bus_rr.o_send_en, 0);
    @(negedge clk);
    chk("send_en", bus_rr.o_send_en, 1);
    chk("sdat_rr", bus_rr.o_send_data, words[er]);
    chk("sdat_fx", bus_fx.o_send_data, words[ef]);
    if (ack) begin
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        chk("send_hold", bus_rr.o_send_en, 1);
      end
      busy = 1'b1;
      for (int d = 0; d < blen; d++) begin
        @(negedge clk);
        chk("wait_sen", bus_rr.o_send_en, 0);
        chk("wait_sdat", bus_rr.o_send_data, 0);
        chk("wait_done", bus_rr.o_done, 0);
        if (drop_cen && d == 0) cen = 1'b0;
      end
      busy = 1'b0;
      @(negedge clk);
      chk("done_rr", bus_rr.o_done, 1);
      chk("done_fx", bus_fx.o_done, 1);
      chk("done_noto", bus_rr.o_timeout, 0);
    end else begin
      for (int d = 1; d < 4; d++) begin
        @(negedge clk);
        chk("to_sen", bus_rr.o_send_en, 1);
      end
      @(negedge clk);
      chk("to_rr", bus_rr.o_timeout, 1);
      chk("to_fx", bus_fx.o_timeout, 1);
      chk("to_nodone", bus_rr.o_done, 0);
      chk("to_sen_off", bus_rr.o_send_en, 0);
    end
    if (er > 0) last_fifo = er;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    last_fifo = NS - 1;
    rst   = 1'b1;
    cen   = 1'b0;
    valid = '0;
    busy  = 1'b0;
    for (int s = 0; s < NS; s++) words[s] = '0;

    repeat (3) @(negedge clk);
    all_zero("reset");
    rst = 1'b0;

    valid = '1;
    idle_quiet("idle_no_cen", 5);

    cen  = 1'b1;
    busy = 1'b1;
    idle_quiet("arb_busy_hold", 5);

    frame(4'b1110, 1'b1, 0, 3, 1'b0);
    frame(4'b1111, 1'b1, 1, 3, 1'b0);

    for (int f = 0; f < 6; f++)
      frame(4'b1110, 1'b1, f % 3, 1 + f % 2, 1'b0);

    frame(4'b1010, 1'b0, 0, 0, 1'b0);
    frame(4'b0110, 1'b1, 2, 2, 1'b0);

    valid = 4'b1110;
    busy  = 1'b0;
    wait_read();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_sen", bus_rr.o_send_en, 1);
    rst = 1'b1;
    @(negedge clk);
    all_zero("midrst");
    rst = 1'b0;
    last_fifo = NS - 1;
    frame(4'b1110, 1'b1, 0, 2, 1'b0);

    frame(4'b1100, 1'b1, 1, 2, 1'b1);
    valid = 4'b1111;
    idle_quiet("cen_drop_idle", 10);
    cen = 1'b1;

    for (int f = 0; f < 40; f++) begin
      logic [NS-1:0] v;
      v = NS'($urandom_range(1, (1 << NS) - 1));
      frame(v, ($urandom % 5) != 0,
            int'($urandom_range(0, 2)),
            int'($urandom_range(1, 4)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
